load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum ACCESS cycles without mem_ack before timeout error; range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: execute stage requests an access this cycle.
REQ-005 SHALL have port opcode, input, 7: 7'b0000011 load, 7'b0100011 store.
REQ-006 SHALL have port funct3, input, 3: access size/signedness.
REQ-007 SHALL have port rs1_data, input, 32: base address.
REQ-008 SHALL have port imed, input, 32: sign-extended offset from immediate generator.
REQ-009 SHALL have port rs2_data, input, 32: store data.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: one-cycle pulse, coincident with done, on misalign, illegal funct3 or timeout.
REQ-013 SHALL have port rdata, output, 32: extended load result.
REQ-014 SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out 32, bits[1:0]=0), mem_be (out 4), mem_wdata (out 32), mem_ack (in 1), mem_rdata (in 32).

Function
REQ-015 SHALL implement states IDLE, ACCESS, RESP, ERR.
REQ-016 IDLE: start with load/store opcode SHALL latch ea = rs1_data+imed (mod 2^32), funct3, rs2_data, direction; start with any other opcode SHALL be ignored.
REQ-017 IDLE exit SHALL go to ERR if funct3 illegal (loads legal 000,001,010,100,101; stores legal 000,001,010) or misaligned (half: ea[0]=1; word: ea[1:0]!=0), else to ACCESS.
REQ-018 ACCESS SHALL hold mem_req=1 with mem_addr={ea[31:2],2'b00}, mem_we, mem_be, mem_wdata stable until mem_ack sampled high, then go to RESP.
REQ-019 mem_be SHALL be 4'b0001<<ea[1:0] (byte), 4'b0011<<ea[1:0] (half), 4'b1111 (word), for loads and stores alike.
REQ-020 mem_wdata SHALL be {4{rs2[7:0]}} (sb), {2{rs2[15:0]}} (sh), rs2 (sw); 0 for loads.
REQ-021 Load data SHALL be registered into rdata on the ack cycle: lb/lbu byte lane ea[1:0] sign/zero-extended; lh/lhu half lane ea[1] sign/zero-extended; lw whole word.
REQ-022 rdata SHALL change only on a successful load; stores and errors leave it unchanged.
REQ-023 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; reaching MAX_WAIT SHALL drop mem_req and go to ERR.
REQ-024 RESP SHALL assert done for one cycle, then return to IDLE; ERR SHALL assert done and err for one cycle, then return to IDLE.
REQ-025 Latency: start at cycle N, mem_req from N+1, ack at cycle K, done at K+1; zero-wait ack gives done at N+2; error detected in IDLE gives done at N+1.
REQ-026 start while busy SHALL be ignored; start in the cycle done is high SHALL be ignored (IDLE is reached the cycle after).
REQ-027 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, and busy, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata to 0.
REQ-029 Reset during ACCESS SHALL abandon the access with no done pulse after release.

Structure
REQ-030 Package lsu_pkg SHALL hold opcode constants, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
REQ-031 Byte-lane select/extension and store replication SHALL live in one sub-module, lsu_align.

Verification
REQ-032 lw: rs1=0x1000, imed=0x4, ack after 2 wait cycles, mem_rdata=0xDEADBEEF -> mem_addr=0x1004, mem_be=1111, rdata=0xDEADBEEF, done once.
REQ-033 lb/lbu: ea=0x2003, mem_rdata=0x80000000 -> mem_be=1000; lb rdata=0xFFFFFF80, lbu rdata=0x00000080.
REQ-034 sh: rs1=0x3000, imed=0xFFFFFFFE (-2), rs2=0x1234ABCD -> mem_addr=0x2FFC, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-035 lw at ea=0x1002, and illegal load funct3=011 -> no mem_req, done=err=1 at N+1, rdata unchanged.
REQ-036 No ack for MAX_WAIT=15 cycles -> mem_req drops, done=err=1; a second start during busy is ignored.
REQ-037 rst_n pulled low mid-ACCESS -> mem_req=0 asynchronously, no done after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_ERR    = 2'b11
    } lsu_state_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane enables, store data replication and load lane select/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_load_raw[7:0];
        case (i_addr_lo)
            2'b01:   w_byte = i_load_raw[15:8];
            2'b10:   w_byte = i_load_raw[23:16];
            2'b11:   w_byte = i_load_raw[31:24];
            default: ;
        endcase
        w_half = i_addr_lo[1] ? i_load_raw[31:16] : i_load_raw[15:0];
    end

    always_comb begin
        o_load_data = i_load_raw;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {24'h0, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_data = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes, checks alignment, runs one bus
// access with a bounded wait, and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] imed,
    input  logic [31:0] rs2_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_d;
    logic [31:0] r_ea;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs2;
    logic        r_we;
    logic [7:0]  r_wait;
    logic [7:0]  w_wait_d;
    logic [31:0] r_rdata;

    logic [31:0] w_ea;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_accept;
    logic        w_bad;
    logic        w_in_access;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_ea        = rs1_data + imed;
    assign w_is_load   = (opcode == OPC_LOAD);
    assign w_is_store  = (opcode == OPC_STORE);
    assign w_accept    = (r_state == ST_IDLE) && start && (w_is_load || w_is_store);
    assign w_bad       = !funct3_legal(w_is_store, funct3) || addr_misaligned(funct3, w_ea[1:0]);
    assign w_in_access = (r_state == ST_ACCESS);
    // Counter holds the number of ack-less cycles already spent in ACCESS.
    assign w_timeout   = !mem_ack && (r_wait == 8'(MAX_WAIT - 1));

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        case (r_state)
            ST_IDLE: begin
                w_wait_d = 8'd0;
                if (w_accept) begin
                    w_state_d = w_bad ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    w_state_d = ST_RESP;
                end else if (w_timeout) begin
                    w_state_d = ST_ERR;
                end else begin
                    w_wait_d = r_wait + 8'd1;
                end
            end
            ST_RESP:  w_state_d = ST_IDLE;
            ST_ERR:   w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ea     <= 32'h0;
            r_funct3 <= 3'b000;
            r_rs2    <= 32'h0;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_ea     <= w_ea;
            r_funct3 <= funct3;
            r_rs2    <= rs2_data;
            r_we     <= w_is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'h0;
        end else if (w_in_access && mem_ack && !r_we) begin
            r_rdata <= w_load_data;
        end
    end

    lsu_align u_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_ea[1:0]),
        .i_store_data(r_rs2),
        .i_load_raw  (mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data)
    );

    // Bus outputs are gated to zero outside ACCESS so reset and idle look identical.
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign err       = (r_state == ST_ERR);
    assign rdata     = r_rdata;
    assign mem_req   = w_in_access;
    assign mem_we    = w_in_access && r_we;
    assign mem_addr  = w_in_access ? {r_ea[31:2], 2'b00} : 32'h0;
    assign mem_be    = w_in_access ? w_be : 4'b0000;
    assign mem_wdata = (w_in_access && r_we) ? w_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized transactions against a byte-level reference model.
module tb_load_store_unit;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, imed, rs2_data;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .imed     (imed),
        .rs2_data (rs2_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        int sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz = size_of(f3);
        v  = word >> (8 * off);
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v    = v & mask;
            if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One full transaction; waits >= MAX_WAIT means the memory never answers.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] imm, input logic [31:0] rs2,
                             input int waits, input logic [31:0] mrd);
        logic [31:0] ea;
        int          sz;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        bit          acked;
        ea = rs1 + imm;
        sz = size_of(f3);
        exp_be = 4'(((32'd1 << sz) - 32'd1) << ea[1:0]);
        exp_wd = 32'h0;
        if (st) for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = rs2[8*(i % sz) +: 8];

        check("idle_busy", {31'h0, busy}, 32'h0);
        start = 1'b1; opcode = st ? 7'b0100011 : 7'b0000011; funct3 = f3;
        rs1_data = rs1; imed = imm; rs2_data = rs2; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0; rs1_data = $urandom; imed = $urandom; rs2_data = $urandom;

        if (!is_legal(st, f3) || (ea % sz) != 0) begin
            check("early_req", {31'h0, mem_req}, 32'h0);
            check("early_done_err", {30'h0, done, err}, 32'h3);
            check("early_rdata", rdata, m_rdata);
        end else begin
            acked = 1'b0;
            for (int w = 0; w < int'(MAX_WAIT) && !acked; w++) begin
                check("acc_req_done", {30'h0, mem_req, done}, 32'h2);
                check("acc_addr", mem_addr, ea & ~32'h3);
                check("acc_be", {28'h0, mem_be}, {28'h0, exp_be});
                check("acc_we", {31'h0, mem_we}, {31'h0, st});
                check("acc_wdata", mem_wdata, exp_wd);
                acked     = (w == waits);
                mem_ack   = acked;
                mem_rdata = acked ? mrd : $urandom;
                // A start while busy must be ignored.
                start = $urandom_range(0, 1); opcode = 7'b0000011; funct3 = 3'b010;
                @(negedge clk);
            end
            mem_ack = 1'b0; start = 1'b0;
            if (acked && !st) m_rdata = load_value(f3, ea[1:0], mrd);
            check("end_req", {31'h0, mem_req}, 32'h0);
            check("end_done_err", {30'h0, done, err}, {30'h0, 1'b1, !acked});
            check("end_rdata", rdata, m_rdata);
        end
        // A start in the done cycle must be ignored too.
        start = 1'b1; opcode = 7'b0000011; funct3 = 3'b000; mem_ack = $urandom_range(0, 1);
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        check("post_busy_done", {30'h0, busy, done}, 32'h0);
        check("post_rdata", rdata, m_rdata);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 7'h0; funct3 = 3'h0;
        rs1_data = 32'h0; imed = 32'h0; rs2_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        check("rst_ctl", {28'h0, busy, done, err, mem_req}, 32'h0);
        check("rst_we_be", {27'h0, mem_we, mem_be}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_access(1'b0, 3'b010, 32'h1000, 32'h4, 32'h0, 2, 32'hDEADBEEF);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        do_access(1'b0, 3'b000, 32'h2000, 32'h3, 32'h0, 0, 32'h80000000);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h2000, 32'h3, 32'h0, 1, 32'h80000000);
        check("lbu_rdata", rdata, 32'h00000080);
        do_access(1'b1, 3'b001, 32'h3000, 32'hFFFFFFFE, 32'h1234ABCD, 0, 32'h0);
        do_access(1'b0, 3'b010, 32'h1000, 32'h2, 32'h0, 0, 32'h0);
        do_access(1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 32'h0);
        check("err_rdata_kept", rdata, 32'h00000080);
        do_access(1'b0, 3'b101, 32'h4000, 32'h0, 32'h0, MAX_WAIT + 2, 32'h0);
        do_access(1'b1, 3'b010, 32'h5000, 32'h8, 32'hCAFEF00D, int'(MAX_WAIT) - 1, 32'h0);

        // Ack and non-memory opcodes while idle change nothing.
        start = 1'b1; opcode = 7'b0110011; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        check("idle_ignore", {30'h0, busy, done}, 32'h0);
        check("idle_rdata", rdata, m_rdata);

        // Reset mid-ACCESS: bus drops at once and no completion follows.
        start = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; rs1_data = 32'h6000; imed = 32'h0;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {28'h0, busy, done, err, mem_req}, 32'h0);
        check("async_rst_addr", mem_addr, 32'h0);
        m_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {29'h0, busy, done, mem_req}, 32'h0);
        end
        mem_ack = 1'b0;

        for (int t = 0; t < 150; t++) begin
            logic [31:0] r1;
            logic [31:0] im;
            int          r;
            r1 = $urandom;
            if ($urandom_range(0, 1) == 1) r1 = r1 & ~32'h3;
            im = 32'($urandom_range(0, 7)) - 32'd4;
            r  = $urandom_range(0, 19);
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r1, im, $urandom,
                      (r < 17) ? (r % 4) : int'(MAX_WAIT) + 2, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
